// File: rtl/cgra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cgra_pkg
// Description : Shared CGRA types, including the input prefetcher FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cgra_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } prefetch_state_t;

endpackage
`default_nettype wire

// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_pkg
// Description : OBI request/response bundles shared by bus masters.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Registered-output FIFO with synchronous flush; no fall-through,
//               a pushed word becomes visible at the head one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage, pointers and occupancy; flush discards everything at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_stream_prefetcher.sv
`default_nettype none
// ============================================================================
// Module      : input_stream_prefetcher
// Description : Strided OBI read engine feeding one CGRA input lane. Keeps up
//               to DEPTH reads in flight; credits guarantee a FIFO slot for
//               every returned word.
// Revision    : 1.0 - initial release
// ============================================================================
module input_stream_prefetcher
  import cgra_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic [31:0] input_addr_i,
  input  logic [15:0] input_size_i,
  input  logic [15:0] input_stride_i,
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  output logic [31:0] dout_o,
  output logic        dout_v_o,
  input  logic        dout_r_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  prefetch_state_t state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     size_q, size_d;
  logic [15:0]     stride_q, stride_d;
  logic [15:0]     issued_q, issued_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic            req_q, req_d;

  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   cnt_next;
  logic            fifo_empty;
  logic            fifo_full;
  logic            grant;
  logic            pending;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic            credit_ok;

  assign grant   = req_q & masters_resp_i.gnt;
  assign pending = req_q & ~masters_resp_i.gnt;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign resp_ok = masters_resp_i.rvalid & (outst_q != '0);
  // Responses arriving in the clear cycle are discarded along with the FIFO.
  assign push    = resp_ok & (state_q == FETCH) & ~clear_i;
  assign pop     = dout_v_o & dout_r_i;

  // Occupancy the FIFO will have next cycle, used for credits and completion.
  assign cnt_next = clear_i ? '0
                  : fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  // Outstanding reads: grant and response in the same cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    case ({grant, resp_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  assign credit_ok = ({1'b0, outst_d} + {1'b0, cnt_next}) < LIMIT;

  // Next-state logic: FSM, stream parameters, issue counter and request.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    stride_d = stride_q;
    issued_d = issued_q;

    if (grant) begin
      issued_d = issued_q + 16'd1;
      addr_d   = addr_q + {16'd0, stride_q};
    end

    case (state_q)
      IDLE, DONE: begin
        if (clear_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          addr_d   = input_addr_i;
          size_d   = input_size_i;
          stride_d = input_stride_i;
          issued_d = 16'd0;
          state_d  = (input_size_i == 16'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (clear_i) begin
          // An ungranted request must still complete, so it forces FLUSH.
          state_d = (outst_d == '0 && !pending) ? IDLE : FLUSH;
        end else if (issued_q == size_q && outst_d == '0 && cnt_next == '0) begin
          state_d = DONE;
        end
      end
      FLUSH: begin
        if (outst_d == '0 && !pending) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A waiting request is held without re-checking credits.
    req_d = pending | ((state_d == FETCH) && (issued_d < size_d) && credit_ok);
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      stride_q <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      stride_q <= stride_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      req_q    <= req_d;
    end
  end

  stream_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (masters_resp_i.rdata),
    .pop_i   (pop),
    .flush_i (clear_i),
    .data_o  (dout_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign masters_req_o.req   = req_q;
  assign masters_req_o.addr  = addr_q;
  assign masters_req_o.we    = 1'b0;
  assign masters_req_o.be    = 4'hF;
  assign masters_req_o.wdata = 32'd0;

  assign dout_v_o = ~fifo_empty;
  assign busy_o   = (state_q == FETCH) || (state_q == FLUSH);
  assign done_o   = (state_q == DONE);

  a_credit : assert property (@(posedge clk_i) disable iff (rst_i)
    (({1'b0, outst_q} + {1'b0, fifo_count}) <= LIMIT));

  a_rvalid_expected : assert property (@(posedge clk_i) disable iff (rst_i)
    (masters_resp_i.rvalid |-> (outst_q != '0)));

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop));

endmodule
`default_nettype wire

// File: tb/tb_input_stream_prefetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_stream_prefetcher
// Description : Directed self-checking bench for input_stream_prefetcher with
//               a behavioural OBI memory returning each word's own address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_stream_prefetcher;
  import obi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        clear_i;
  logic [31:0] input_addr_i;
  logic [15:0] input_size_i;
  logic [15:0] input_stride_i;
  obi_req_t    req_s;
  obi_resp_t   resp_s;
  logic [31:0] dout_o;
  logic        dout_v_o;
  logic        dout_r_i;
  logic        busy_o;
  logic        done_o;

  int n_chk  = 0;
  int n_fail = 0;

  input_stream_prefetcher #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .clear_i        (clear_i),
    .input_addr_i   (input_addr_i),
    .input_size_i   (input_size_i),
    .input_stride_i (input_stride_i),
    .masters_req_o  (req_s),
    .masters_resp_i (resp_s),
    .dout_o         (dout_o),
    .dout_v_o       (dout_v_o),
    .dout_r_i       (dout_r_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  // Memory model: decisions made on the falling edge, sampled at the next rise.
  logic        gnt_r = 1'b0;
  logic        rv_r  = 1'b0;
  logic [31:0] rd_r  = '0;
  int          lat = 1;
  int          stall_at = -1;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  logic [31:0] stall_exp = '0;
  int          req_idx = 0;
  int          grant_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] gaddr[$];
  int          rem_q[$];
  logic [31:0] dat_q[$];

  assign resp_s = {gnt_r, rv_r, rd_r};

  always @(negedge clk_i) begin
    if (rst_i) begin
      gnt_r = 1'b0;
      rv_r  = 1'b0;
      rem_q.delete();
      dat_q.delete();
    end else begin
      for (int i = 0; i < rem_q.size(); i++) rem_q[i] = rem_q[i] - 1;
      rv_r = 1'b0;
      if (rem_q.size() > 0 && rem_q[0] <= 0) begin
        rv_r = 1'b1;
        rd_r = dat_q.pop_front();
        void'(rem_q.pop_front());
        resp_cnt++;
      end
      gnt_r = 1'b0;
      if (req_s.req) begin
        if (req_idx == stall_at && stall_left > 0) begin
          stall_left--;
          stall_seen++;
          if (req_s.addr != stall_exp) stall_bad++;
        end else begin
          gnt_r = 1'b1;
          req_idx++;
          grant_cnt++;
          gaddr.push_back(req_s.addr);
          rem_q.push_back(lat);
          dat_q.push_back(req_s.addr);
        end
      end
    end
  end

  // Output monitor: records every accepted word and the rise of done.
  logic [31:0] got[$];
  int          got_cyc[$];
  int          done_rise = -1;
  logic        done_prev = 1'b0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (dout_v_o && dout_r_i) begin
        got.push_back(dout_o);
        got_cyc.push_back(cyc);
      end
      if (done_o && !done_prev) done_rise = cyc;
    end
    done_prev = done_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_log();
    got.delete();
    got_cyc.delete();
    gaddr.delete();
    grant_cnt = 0;
    resp_cnt  = 0;
    req_idx   = 0;
    done_rise = -1;
  endtask

  task automatic start_stream(input logic [31:0] a, input logic [15:0] n, input logic [15:0] s);
    input_addr_i   = a;
    input_size_i   = n;
    input_stride_i = s;
    start_i        = 1'b1;
    step();
    start_i        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, done_o, 1);
    step();
  endtask

  task automatic check_words(input string tag, input logic [31:0] base, input logic [31:0] stride, input int n);
    check_eq({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) check_eq($sformatf("%s_w%0d", tag, i), got[i], base + stride * i);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    clear_i = 1'b0;
    input_addr_i = '0;
    input_size_i = '0;
    input_stride_i = '0;
    dout_r_i = 1'b0;
    repeat (3) step();

    check_eq("rst_req",    req_s.req,  0);
    check_eq("rst_addr",   req_s.addr, 0);
    check_eq("rst_dout_v", dout_v_o,   0);
    check_eq("rst_dout",   dout_o,     0);
    check_eq("rst_busy",   busy_o,     0);
    check_eq("rst_done",   done_o,     0);
    rst_i = 1'b0;
    step();

    // Basic strided fetch with full-rate bus and consumer.
    dout_r_i = 1'b1;
    lat = 1;
    reset_log();
    start_stream(32'h1000, 16'd4, 16'd8);
    check_eq("issue_req",  req_s.req,  1);
    check_eq("issue_addr", req_s.addr, 32'h1000);
    check_eq("issue_busy", busy_o,     1);
    wait_done("basic_done", 50);
    check_words("basic", 32'h1000, 32'd8, 4);
    if (got_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check_eq($sformatf("basic_cyc%0d", i), got_cyc[i], got_cyc[0] + i);
      check_eq("basic_done_t", done_rise, got_cyc[3] + 1);
    end
    step();
    check_eq("done_level", done_o, 1);

    // Backpressure: only DEPTH reads may be accepted while the lane is stalled.
    dout_r_i = 1'b0;
    reset_log();
    start_stream(32'h2000, 16'd16, 16'd4);
    repeat (20) step();
    check_eq("bp_grants", grant_cnt, 4);
    check_eq("bp_req",    req_s.req, 0);
    check_eq("bp_head",   dout_o,    32'h2000);
    dout_r_i = 1'b1;
    wait_done("bp_done", 200);
    check_words("bp", 32'h2000, 32'd4, 16);

    // Grant withheld for five cycles on the second request.
    reset_log();
    stall_at   = 1;
    stall_left = 5;
    stall_seen = 0;
    stall_bad  = 0;
    stall_exp  = 32'h3010;
    start_stream(32'h3000, 16'd4, 16'h10);
    wait_done("stall_done", 100);
    check_eq("stall_cycles", stall_seen, 5);
    check_eq("stall_addr_moved", stall_bad, 0);
    check_words("stall", 32'h3000, 32'h10, 4);
    stall_at = -1;

    // Clear from DONE returns to IDLE.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_eq("clr_done", done_o, 0);
    check_eq("clr_busy", busy_o, 0);

    // Zero-size stream completes immediately with no bus traffic.
    reset_log();
    start_stream(32'h4000, 16'd0, 16'd4);
    check_eq("zero_done", done_o,    1);
    check_eq("zero_req",  req_s.req, 0);
    step();
    step();
    check_eq("zero_grants", grant_cnt, 0);

    // Address wrap-around.
    reset_log();
    start_stream(32'hFFFF_FFFC, 16'd2, 16'd4);
    wait_done("wrap_done", 50);
    check_eq("wrap_gcount", gaddr.size(), 2);
    if (gaddr.size() == 2) begin
      check_eq("wrap_a0", gaddr[0], 32'hFFFF_FFFC);
      check_eq("wrap_a1", gaddr[1], 32'h0000_0000);
    end
    check_words("wrap", 32'hFFFF_FFFC, 32'd4, 2);

    // Clear with three reads outstanding and a four-cycle response latency.
    lat = 4;
    reset_log();
    start_stream(32'h7000, 16'd3, 16'd4);
    step();
    step();
    step();
    check_eq("flush_outst", grant_cnt - resp_cnt, 3);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_eq("flush_busy",   busy_o,    1);
    check_eq("flush_done",   done_o,    0);
    check_eq("flush_dout_v", dout_v_o,  0);
    check_eq("flush_req",    req_s.req, 0);
    begin
      int n = 0;
      while (busy_o && n < 50) begin
        step();
        n++;
      end
    end
    check_eq("flush_idle",      busy_o,     0);
    check_eq("flush_swallowed", resp_cnt,   3);
    check_eq("flush_no_pop",    got.size(), 0);
    reset_log();
    start_stream(32'h7100, 16'd2, 16'd4);
    wait_done("after_flush_done", 60);
    check_words("after_flush", 32'h7100, 32'd4, 2);

    // A start pulse during FETCH must not disturb the running stream.
    lat = 1;
    reset_log();
    start_stream(32'h6000, 16'd4, 16'd4);
    input_addr_i   = 32'h9000;
    input_size_i   = 16'd1;
    input_stride_i = 16'h100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done("ign_done", 50);
    check_words("ign", 32'h6000, 32'd4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
